bfly10_stage: RTL and testbench

Radix-2 decimation-in-frequency butterfly stage that produces the sum/difference lanes consumed by the stage-10 twiddle multiplier. It accepts a 128-sample frame as eight beats of 16 complex samples. It buffers the first half-frame and pairs sample n with sample n+64. It emits four valid beats of sum/diff data per frame, together with the `twd10_valid` strobe that drives the downstream twiddle counter.

---
 rtl/fft_pkg.sv | 44 ++++
 rtl/bfly10_stage_if.sv | 28 ++
 rtl/bfly2_sat.sv | 19 +
 rtl/counter.sv | 25 ++
 rtl/twd_mul10.sv | 47 ++++
 rtl/bfly10_stage.sv | 92 +++++++++
 tb/tb_bfly10_stage.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath types, sizes and saturating arithmetic helpers.
package fft_pkg;

  localparam int unsigned WIDTH       = 12;
  localparam int unsigned LANES       = 16;
  localparam int unsigned HALF_BEATS  = 4;
  localparam int unsigned FRAME_BEATS = 2 * HALF_BEATS;
  localparam int unsigned IDX_W       = $clog2(HALF_BEATS);

  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } cplx_t;

  // Clamp a WIDTH+1 bit result back into the WIDTH bit signed range.
  function automatic logic signed [WIDTH-1:0] sat_clip(input logic signed [WIDTH:0] s);
    if (s[WIDTH] != s[WIDTH-1]) begin
      return s[WIDTH] ? SAT_MIN : SAT_MAX;
    end
    return s[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] ea;
    logic signed [WIDTH:0] eb;
    ea = a;
    eb = b;
    return sat_clip(ea + eb);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] ea;
    logic signed [WIDTH:0] eb;
    ea = a;
    eb = b;
    return sat_clip(ea - eb);
  endfunction

endpackage

// File: rtl/bfly10_stage_if.sv
// Beat-level bus between the frame source, the stage-10 butterfly and the twiddle stage.
interface bfly10_stage_if
  import fft_pkg::*;
;
  logic                    din_valid;
  logic signed [WIDTH-1:0] din_re [0:LANES-1];
  logic signed [WIDTH-1:0] din_im [0:LANES-1];

  logic                    twd10_valid;
  logic [IDX_W-1:0]        o_bfly10_idx;
  logic signed [WIDTH-1:0] o_10bfly_sum_re  [0:LANES-1];
  logic signed [WIDTH-1:0] o_10bfly_sum_im  [0:LANES-1];
  logic signed [WIDTH-1:0] o_10bfly_diff_re [0:LANES-1];
  logic signed [WIDTH-1:0] o_10bfly_diff_im [0:LANES-1];

  modport master (
    output din_valid, din_re, din_im,
    input  twd10_valid, o_bfly10_idx,
    input  o_10bfly_sum_re, o_10bfly_sum_im, o_10bfly_diff_re, o_10bfly_diff_im
  );

  modport slave (
    input  din_valid, din_re, din_im,
    output twd10_valid, o_bfly10_idx,
    output o_10bfly_sum_re, o_10bfly_sum_im, o_10bfly_diff_re, o_10bfly_diff_im
  );

endinterface

// File: rtl/bfly2_sat.sv
// Single-lane complex radix-2 butterfly with saturated sum and difference.
module bfly2_sat
  import fft_pkg::*;
(
  input  cplx_t i_a,
  input  cplx_t i_b,
  output cplx_t o_sum_c,
  output cplx_t o_diff_c
);

  // Real and imaginary parts saturate independently.
  always_comb begin
    o_sum_c.re  = sat_add(i_a.re, i_b.re);
    o_sum_c.im  = sat_add(i_a.im, i_b.im);
    o_diff_c.re = sat_sub(i_a.re, i_b.re);
    o_diff_c.im = sat_sub(i_a.im, i_b.im);
  end

endmodule

// File: rtl/counter.sv
// Free-running modulo counter that advances only while enabled.
module counter #(
  parameter int unsigned COUNT_MAX_VAL = 8,
  parameter int unsigned CNT_W         = $clog2(COUNT_MAX_VAL)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count 0..COUNT_MAX_VAL-1 and wrap, holding while disabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= (r_count == CNT_W'(COUNT_MAX_VAL - 1)) ? '0 : r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/twd_mul10.sv
// Stage-10 twiddle stage: passes the sum lane, rotates the diff lane by -j on the last beat.
module twd_mul10
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_idx,
  input  cplx_t            i_sum,
  input  cplx_t            i_diff,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx,
  output cplx_t            o_sum,
  output cplx_t            o_diff
);

  logic  w_rot;
  cplx_t w_twd;

  // Twiddle is 1 for beats 0..HALF_BEATS-2 and -j for the last beat of the half-frame.
  always_comb begin
    w_rot    = (i_idx == IDX_W'(HALF_BEATS - 1));
    w_twd    = i_diff;
    if (w_rot) begin
      w_twd.re = i_diff.im;
      w_twd.im = sat_sub('0, i_diff.re);
    end
  end

  // Register the rotated beat; data holds between valid beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid <= 1'b0;
      o_idx   <= '0;
      o_sum   <= '0;
      o_diff  <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_idx  <= i_idx;
        o_sum  <= i_sum;
        o_diff <= w_twd;
      end
    end
  end

endmodule

// File: rtl/bfly10_stage.sv
// Stage-10 DIF butterfly: buffers half a frame, pairs sample n with n+64, emits sum/diff beats.
module bfly10_stage
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  bfly10_stage_if.slave bus
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [CNT_W-1:0] w_beat_cnt;
  logic [IDX_W-1:0] w_k;
  logic             w_fill;
  logic             w_emit;

  cplx_t w_din  [LANES];
  cplx_t w_a    [LANES];
  cplx_t w_sum  [LANES];
  cplx_t w_diff [LANES];

  cplx_t r_buf  [HALF_BEATS][LANES];
  cplx_t r_sum  [LANES];
  cplx_t r_diff [LANES];
  logic             r_valid;
  logic [IDX_W-1:0] r_idx;

  // Beat position within the frame; alignment comes purely from reset.
  counter #(
    .COUNT_MAX_VAL(FRAME_BEATS)
  ) u_beat_cnt (
    .clk  (clk),
    .rstn (rstn),
    .en   (bus.din_valid),
    .count(w_beat_cnt)
  );

  assign w_k    = w_beat_cnt[IDX_W-1:0];
  assign w_fill = ~w_beat_cnt[CNT_W-1];
  assign w_emit = bus.din_valid & ~w_fill;

  for (genvar j = 0; j < int'(LANES); j++) begin : g_lane
    assign w_din[j] = '{re: bus.din_re[j], im: bus.din_im[j]};
    assign w_a[j]   = r_buf[w_k][j];

    bfly2_sat u_bfly (
      .i_a     (w_a[j]),
      .i_b     (w_din[j]),
      .o_sum_c (w_sum[j]),
      .o_diff_c(w_diff[j])
    );

    assign bus.o_10bfly_sum_re[j]  = r_sum[j].re;
    assign bus.o_10bfly_sum_im[j]  = r_sum[j].im;
    assign bus.o_10bfly_diff_re[j] = r_diff[j].re;
    assign bus.o_10bfly_diff_im[j] = r_diff[j].im;
  end

  // Half-frame buffer; a slot is rewritten only by the next frame's fill beat.
  always_ff @(posedge clk) begin
    if (bus.din_valid && w_fill) begin
      for (int j = 0; j < int'(LANES); j++) begin
        r_buf[w_k][j] <= w_din[j];
      end
    end
  end

  // Output beat register; data and index hold between compute beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      for (int j = 0; j < int'(LANES); j++) begin
        r_sum[j]  <= '0;
        r_diff[j] <= '0;
      end
    end else begin
      r_valid <= w_emit;
      if (w_emit) begin
        r_idx <= w_k;
        for (int j = 0; j < int'(LANES); j++) begin
          r_sum[j]  <= w_sum[j];
          r_diff[j] <= w_diff[j];
        end
      end
    end
  end

  assign bus.twd10_valid  = r_valid;
  assign bus.o_bfly10_idx = r_idx;

endmodule

// File: tb/tb_bfly10_stage.sv
// Directed self-checking bench for bfly10_stage and the downstream twd_mul10 stage.
module tb_bfly10_stage;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bfly10_stage_if bus ();

  bfly10_stage dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  logic             t_valid;
  logic [IDX_W-1:0] t_idx;
  cplx_t            t_sum;
  cplx_t            t_diff;
  logic             m_valid;
  logic [IDX_W-1:0] m_idx;
  cplx_t            m_sum;
  cplx_t            m_diff;

  twd_mul10 u_twd (
    .clk    (clk),
    .rstn   (rstn),
    .i_valid(t_valid),
    .i_idx  (t_idx),
    .i_sum  (t_sum),
    .i_diff (t_diff),
    .o_valid(m_valid),
    .o_idx  (m_idx),
    .o_sum  (m_sum),
    .o_diff (m_diff)
  );

  int n_vec = 0;
  int n_err = 0;

  logic signed [WIDTH-1:0] in_re [LANES];
  logic signed [WIDTH-1:0] in_im [LANES];
  logic signed [WIDTH-1:0] e_sr  [LANES];
  logic signed [WIDTH-1:0] e_si  [LANES];
  logic signed [WIDTH-1:0] e_dr  [LANES];
  logic signed [WIDTH-1:0] e_di  [LANES];

  function automatic int pat_re(input int f, input int b, input int j);
    return 100 * f + 10 * b + j;
  endfunction

  function automatic int pat_im(input int f, input int b, input int j);
    return 50 * f - b - j;
  endfunction

  // Present one input beat, then step to just after the sampling edge.
  task automatic apply(input logic v);
    @(negedge clk);
    bus.din_valid = v;
    for (int j = 0; j < int'(LANES); j++) begin
      bus.din_re[j] = in_re[j];
      bus.din_im[j] = in_im[j];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.din_valid = 1'b0;
    for (int j = 0; j < int'(LANES); j++) begin
      in_re[j] = '0; in_im[j] = '0;
      bus.din_re[j] = '0; bus.din_im[j] = '0;
      e_sr[j] = '0; e_si[j] = '0; e_dr[j] = '0; e_di[j] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.twd10_valid !== 1'b0 || bus.o_bfly10_idx !== 2'd0) begin
      n_err++;
      $display("FAIL reset ctl: got valid=%b idx=%0d, want valid=0 idx=0", bus.twd10_valid, bus.o_bfly10_idx);
    end
    for (int j = 0; j < int'(LANES); j++) begin
      n_vec++;
      if (bus.o_10bfly_sum_re[j] !== e_sr[j] || bus.o_10bfly_sum_im[j] !== e_si[j] ||
          bus.o_10bfly_diff_re[j] !== e_dr[j] || bus.o_10bfly_diff_im[j] !== e_di[j]) begin
        n_err++;
        $display("FAIL reset lane %0d: got sum(%0d,%0d) diff(%0d,%0d), want all 0", j,
                 bus.o_10bfly_sum_re[j], bus.o_10bfly_sum_im[j], bus.o_10bfly_diff_re[j], bus.o_10bfly_diff_im[j]);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single_frame();
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < int'(LANES); j++) begin
        in_re[j] = (b < 4) ? 12'(j) : 12'(1);
        in_im[j] = '0;
        e_sr[j] = 12'(j + 1); e_si[j] = '0; e_dr[j] = 12'(j - 1); e_di[j] = '0;
      end
      apply(1'b1);
      n_vec++;
      if (b < 4) begin
        if (bus.twd10_valid !== 1'b0) begin
          n_err++;
          $display("FAIL single fill beat %0d: got valid=%b, want 0", b, bus.twd10_valid);
        end
      end else begin
        if (bus.twd10_valid !== 1'b1 || bus.o_bfly10_idx !== 2'(b - 4)) begin
          n_err++;
          $display("FAIL single beat %0d ctl: got valid=%b idx=%0d, want valid=1 idx=%0d",
                   b, bus.twd10_valid, bus.o_bfly10_idx, b - 4);
        end
        for (int j = 0; j < int'(LANES); j++) begin
          n_vec++;
          if (bus.o_10bfly_sum_re[j] !== e_sr[j] || bus.o_10bfly_sum_im[j] !== e_si[j] ||
              bus.o_10bfly_diff_re[j] !== e_dr[j] || bus.o_10bfly_diff_im[j] !== e_di[j]) begin
            n_err++;
            $display("FAIL single beat %0d lane %0d: got sum(%0d,%0d) diff(%0d,%0d), want sum(%0d,%0d) diff(%0d,%0d)",
                     b, j, bus.o_10bfly_sum_re[j], bus.o_10bfly_sum_im[j], bus.o_10bfly_diff_re[j],
                     bus.o_10bfly_diff_im[j], e_sr[j], e_si[j], e_dr[j], e_di[j]);
          end
        end
      end
    end
  endtask

  task automatic test_saturation();
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < int'(LANES); j++) begin
        in_re[j] = '0; in_im[j] = '0;
        e_sr[j] = '0; e_si[j] = '0; e_dr[j] = '0; e_di[j] = '0;
      end
      case (b)
        0: begin in_re[0] = 12'(2047);  in_im[0] = 12'(-2048); end
        1: begin in_re[1] = 12'(-2048); in_im[1] = 12'(-2048); end
        4: begin
          in_re[0] = 12'(2047); in_im[0] = 12'(2047);
          e_sr[0] = 12'(2047); e_si[0] = 12'(-1); e_dr[0] = '0; e_di[0] = 12'(-2048);
        end
        5: begin
          in_re[1] = 12'(-2048); in_im[1] = 12'(2047);
          e_sr[1] = 12'(-2048); e_si[1] = 12'(-1); e_dr[1] = '0; e_di[1] = 12'(-2048);
        end
        default: ;
      endcase
      apply(1'b1);
      if (b == 4 || b == 5) begin
        n_vec++;
        if (bus.twd10_valid !== 1'b1 || bus.o_bfly10_idx !== 2'(b - 4)) begin
          n_err++;
          $display("FAIL sat beat %0d ctl: got valid=%b idx=%0d, want valid=1 idx=%0d",
                   b, bus.twd10_valid, bus.o_bfly10_idx, b - 4);
        end
        for (int j = 0; j < int'(LANES); j++) begin
          n_vec++;
          if (bus.o_10bfly_sum_re[j] !== e_sr[j] || bus.o_10bfly_sum_im[j] !== e_si[j] ||
              bus.o_10bfly_diff_re[j] !== e_dr[j] || bus.o_10bfly_diff_im[j] !== e_di[j]) begin
            n_err++;
            $display("FAIL sat beat %0d lane %0d: got sum(%0d,%0d) diff(%0d,%0d), want sum(%0d,%0d) diff(%0d,%0d)",
                     b, j, bus.o_10bfly_sum_re[j], bus.o_10bfly_sum_im[j], bus.o_10bfly_diff_re[j],
                     bus.o_10bfly_diff_im[j], e_sr[j], e_si[j], e_dr[j], e_di[j]);
          end
        end
      end
    end
  endtask

  task automatic test_gapped();
    int pulses;
    pulses = 0;
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < int'(LANES); j++) begin
        if (b < 4) begin
          in_re[j] = 12'(j + b); in_im[j] = 12'(2 * j);
        end else begin
          in_re[j] = 12'(b - 4); in_im[j] = 12'(1);
          e_sr[j] = 12'(j + 2 * (b - 4)); e_si[j] = 12'(2 * j + 1);
          e_dr[j] = 12'(j);               e_di[j] = 12'(2 * j - 1);
        end
      end
      apply(1'b1);
      if (bus.twd10_valid === 1'b1) pulses++;
      n_vec++;
      if (bus.twd10_valid !== ((b >= 4) ? 1'b1 : 1'b0) ||
          (b >= 4 && bus.o_bfly10_idx !== 2'(b - 4))) begin
        n_err++;
        $display("FAIL gapped beat %0d ctl: got valid=%b idx=%0d, want valid=%0d idx=%0d",
                 b, bus.twd10_valid, bus.o_bfly10_idx, (b >= 4), (b >= 4) ? b - 4 : 0);
      end
      if (b >= 4) begin
        for (int j = 0; j < int'(LANES); j++) begin
          n_vec++;
          if (bus.o_10bfly_sum_re[j] !== e_sr[j] || bus.o_10bfly_sum_im[j] !== e_si[j] ||
              bus.o_10bfly_diff_re[j] !== e_dr[j] || bus.o_10bfly_diff_im[j] !== e_di[j]) begin
            n_err++;
            $display("FAIL gapped beat %0d lane %0d: got sum(%0d,%0d) diff(%0d,%0d), want sum(%0d,%0d) diff(%0d,%0d)",
                     b, j, bus.o_10bfly_sum_re[j], bus.o_10bfly_sum_im[j], bus.o_10bfly_diff_re[j],
                     bus.o_10bfly_diff_im[j], e_sr[j], e_si[j], e_dr[j], e_di[j]);
          end
        end
      end
      for (int j = 0; j < int'(LANES); j++) begin
        in_re[j] = 12'(999); in_im[j] = 12'(-999);
      end
      apply(1'b0);
      if (bus.twd10_valid === 1'b1) pulses++;
      n_vec++;
      if (bus.twd10_valid !== 1'b0) begin
        n_err++;
        $display("FAIL gapped gap after beat %0d: got valid=%b, want 0", b, bus.twd10_valid);
      end
      if (b >= 4) begin
        n_vec++;
        if (bus.o_10bfly_sum_re[LANES-1] !== e_sr[LANES-1] || bus.o_10bfly_diff_im[LANES-1] !== e_di[LANES-1]) begin
          n_err++;
          $display("FAIL gapped hold after beat %0d: got sum_re=%0d diff_im=%0d, want %0d %0d", b,
                   bus.o_10bfly_sum_re[LANES-1], bus.o_10bfly_diff_im[LANES-1], e_sr[LANES-1], e_di[LANES-1]);
        end
      end
    end
    n_vec++;
    if (pulses !== 4) begin
      n_err++;
      $display("FAIL gapped pulse count: got %0d, want 4", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int n_out;
    int f;
    int b;
    int k;
    n_out = 0;
    for (int s = 0; s < 16; s++) begin
      f = s / 8;
      b = s % 8;
      k = b - 4;
      for (int j = 0; j < int'(LANES); j++) begin
        in_re[j] = 12'(pat_re(f, b, j));
        in_im[j] = 12'(pat_im(f, b, j));
        if (b >= 4) begin
          e_sr[j] = 12'(pat_re(f, k, j) + pat_re(f, b, j));
          e_si[j] = 12'(pat_im(f, k, j) + pat_im(f, b, j));
          e_dr[j] = 12'(pat_re(f, k, j) - pat_re(f, b, j));
          e_di[j] = 12'(pat_im(f, k, j) - pat_im(f, b, j));
        end
      end
      apply(1'b1);
      if (bus.twd10_valid === 1'b1) n_out++;
      n_vec++;
      if (bus.twd10_valid !== ((b >= 4) ? 1'b1 : 1'b0) ||
          (b >= 4 && bus.o_bfly10_idx !== 2'(k))) begin
        n_err++;
        $display("FAIL b2b frame %0d beat %0d ctl: got valid=%b idx=%0d, want valid=%0d idx=%0d",
                 f, b, bus.twd10_valid, bus.o_bfly10_idx, (b >= 4), (b >= 4) ? k : 0);
      end
      if (b >= 4) begin
        for (int j = 0; j < int'(LANES); j++) begin
          n_vec++;
          if (bus.o_10bfly_sum_re[j] !== e_sr[j] || bus.o_10bfly_sum_im[j] !== e_si[j] ||
              bus.o_10bfly_diff_re[j] !== e_dr[j] || bus.o_10bfly_diff_im[j] !== e_di[j]) begin
            n_err++;
            $display("FAIL b2b frame %0d beat %0d lane %0d: got sum(%0d,%0d) diff(%0d,%0d), want sum(%0d,%0d) diff(%0d,%0d)",
                     f, b, j, bus.o_10bfly_sum_re[j], bus.o_10bfly_sum_im[j], bus.o_10bfly_diff_re[j],
                     bus.o_10bfly_diff_im[j], e_sr[j], e_si[j], e_dr[j], e_di[j]);
          end
        end
      end
    end
    n_vec++;
    if (n_out !== 8) begin
      n_err++;
      $display("FAIL b2b output beat count: got %0d, want 8", n_out);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < int'(LANES); j++) begin
        in_re[j] = 12'(pat_re(2, b, j));
        in_im[j] = 12'(pat_im(2, b, j));
      end
      apply(1'b1);
    end
    n_vec++;
    if (bus.twd10_valid !== 1'b1 || bus.o_bfly10_idx !== 2'd1) begin
      n_err++;
      $display("FAIL midrst pre ctl: got valid=%b idx=%0d, want valid=1 idx=1", bus.twd10_valid, bus.o_bfly10_idx);
    end
    #2;
    rstn = 1'b0;
    bus.din_valid = 1'b0;
    #1;
    n_vec++;
    if (bus.twd10_valid !== 1'b0 || bus.o_bfly10_idx !== 2'd0) begin
      n_err++;
      $display("FAIL midrst ctl: got valid=%b idx=%0d, want valid=0 idx=0", bus.twd10_valid, bus.o_bfly10_idx);
    end
    for (int j = 0; j < int'(LANES); j++) begin
      n_vec++;
      if (bus.o_10bfly_sum_re[j] !== 12'd0 || bus.o_10bfly_sum_im[j] !== 12'd0 ||
          bus.o_10bfly_diff_re[j] !== 12'd0 || bus.o_10bfly_diff_im[j] !== 12'd0) begin
        n_err++;
        $display("FAIL midrst lane %0d: got sum(%0d,%0d) diff(%0d,%0d), want all 0", j,
                 bus.o_10bfly_sum_re[j], bus.o_10bfly_sum_im[j], bus.o_10bfly_diff_re[j], bus.o_10bfly_diff_im[j]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int b = 0; b < 8; b++) begin
      k = b - 4;
      for (int j = 0; j < int'(LANES); j++) begin
        in_re[j] = 12'(pat_re(3, b, j));
        in_im[j] = 12'(pat_im(3, b, j));
        if (b >= 4) begin
          e_sr[j] = 12'(pat_re(3, k, j) + pat_re(3, b, j));
          e_si[j] = 12'(pat_im(3, k, j) + pat_im(3, b, j));
          e_dr[j] = 12'(pat_re(3, k, j) - pat_re(3, b, j));
          e_di[j] = 12'(pat_im(3, k, j) - pat_im(3, b, j));
        end
      end
      apply(1'b1);
      n_vec++;
      if (bus.twd10_valid !== ((b >= 4) ? 1'b1 : 1'b0) ||
          (b >= 4 && bus.o_bfly10_idx !== 2'(k))) begin
        n_err++;
        $display("FAIL midrst fresh beat %0d ctl: got valid=%b idx=%0d, want valid=%0d idx=%0d",
                 b, bus.twd10_valid, bus.o_bfly10_idx, (b >= 4), (b >= 4) ? k : 0);
      end
      if (b >= 4) begin
        for (int j = 0; j < int'(LANES); j++) begin
          n_vec++;
          if (bus.o_10bfly_sum_re[j] !== e_sr[j] || bus.o_10bfly_sum_im[j] !== e_si[j] ||
              bus.o_10bfly_diff_re[j] !== e_dr[j] || bus.o_10bfly_diff_im[j] !== e_di[j]) begin
            n_err++;
            $display("FAIL midrst fresh beat %0d lane %0d: got sum(%0d,%0d) diff(%0d,%0d), want sum(%0d,%0d) diff(%0d,%0d)",
                     b, j, bus.o_10bfly_sum_re[j], bus.o_10bfly_sum_im[j], bus.o_10bfly_diff_re[j],
                     bus.o_10bfly_diff_im[j], e_sr[j], e_si[j], e_dr[j], e_di[j]);
          end
        end
      end
    end
  endtask

  task automatic test_twiddle();
    cplx_t e_sum;
    cplx_t e_diff;
    e_sum = '{re: 12'(3), im: 12'(0)};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      t_valid = 1'b1;
      t_idx   = 2'(k);
      t_sum   = '{re: 12'(3), im: 12'(0)};
      t_diff  = '{re: 12'(5), im: 12'(7)};
      e_diff  = (k < 3) ? '{re: 12'(5), im: 12'(7)} : '{re: 12'(7), im: 12'(-5)};
      @(posedge clk);
      #1;
      n_vec++;
      if (m_valid !== 1'b1 || m_idx !== 2'(k) || m_sum !== e_sum || m_diff !== e_diff) begin
        n_err++;
        $display("FAIL twiddle idx %0d: got valid=%b idx=%0d sum(%0d,%0d) diff(%0d,%0d), want valid=1 idx=%0d sum(%0d,%0d) diff(%0d,%0d)",
                 k, m_valid, m_idx, m_sum.re, m_sum.im, m_diff.re, m_diff.im,
                 k, e_sum.re, e_sum.im, e_diff.re, e_diff.im);
      end
    end
    @(negedge clk);
    t_valid = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL twiddle valid drop: got %b, want 0", m_valid);
    end
  endtask

  initial begin
    t_valid = 1'b0;
    t_idx   = '0;
    t_sum   = '0;
    t_diff  = '0;
    test_reset();
    test_single_frame();
    test_saturation();
    test_gapped();
    test_back_to_back();
    test_reset_mid();
    test_twiddle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
